// File: rtl/hazard_ctrl_if.sv
// Decode-side control bundle between the pipeline datapath (master) and the
// hazard/sequencing controller (slave).
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       id_rd;
    logic             id_wb_en;
    logic [1:0]       id_wb_sel;
    logic             ex_redirect;
    logic             mem_busy;

    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             stall_mem;
    logic             flush_id;
    logic             bubble_ex;
    logic             bubble_wb;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wb_en, id_wb_sel, ex_redirect, mem_busy,
        input  stall_if, stall_id, stall_ex, stall_mem, flush_id,
               bubble_ex, bubble_wb, fwd_a_sel, fwd_b_sel,
               mem_timeout_err, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wb_en, id_wb_sel, ex_redirect, mem_busy,
        output stall_if, stall_id, stall_ex, stall_mem, flush_id,
               bubble_ex, bubble_wb, fwd_a_sel, fwd_b_sel,
               mem_timeout_err, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: load-use
// stalls, EX redirects, operand forwarding, data-memory freezes and timeout.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wb_en;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
    } ex_entry_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wb_en;
        logic       is_load;
    } mem_entry_t;

    // A load in WB forwards like any other result, so its type is not kept.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wb_en;
    } wb_entry_t;

    state_t             state_reg;
    logic [WAIT_W-1:0]  wait_cnt_reg;
    logic [CNT_W-1:0]   stall_cnt_reg;
    ex_entry_t          ex_q;
    mem_entry_t         mem_q;
    wb_entry_t          wb_q;

    function automatic logic dest_hit(input logic       valid,
                                      input logic       wb_en,
                                      input logic [4:0] rd,
                                      input logic [4:0] r);
        return valid && wb_en && (rd == r) && (r != 5'd0);
    endfunction

    logic in_error;
    logic freeze;
    logic active;
    logic hold_all;
    logic load_use;
    logic redirect;
    logic stall_id_w;
    logic accept_id;

    assign in_error = (state_reg == ERROR);
    assign freeze   = rst_n && !in_error && bus.mem_busy;
    assign active   = rst_n && !in_error && !bus.mem_busy;
    assign hold_all = freeze || in_error;

    logic [1:0][4:0] id_src;
    logic [1:0]      id_use;
    logic [1:0]      id_load_hit;
    logic [1:0][4:0] ex_src;
    logic [1:0]      ex_use;
    logic [1:0]      mem_fwd;
    logic [1:0]      wb_fwd;
    logic [1:0]      mem_load_hit;
    logic [1:0][1:0] fwd_sel;

    assign id_src = {bus.id_rs2, bus.id_rs1};
    assign id_use = {bus.id_use_rs2, bus.id_use_rs1};
    assign ex_src = {ex_q.rs2, ex_q.rs1};
    assign ex_use = {ex_q.use_rs2, ex_q.use_rs1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            assign id_load_hit[gi] = id_use[gi] && ex_q.is_load &&
                                     dest_hit(ex_q.valid, ex_q.wb_en, ex_q.rd, id_src[gi]);

            // A load still in MEM has no data yet; the load-use stall keeps
            // its consumer out of EX until the load reaches WB.
            assign mem_load_hit[gi] = ex_q.valid && ex_use[gi] && mem_q.is_load &&
                                      dest_hit(mem_q.valid, mem_q.wb_en, mem_q.rd, ex_src[gi]);
            assign mem_fwd[gi]      = ex_q.valid && ex_use[gi] && !mem_q.is_load &&
                                      dest_hit(mem_q.valid, mem_q.wb_en, mem_q.rd, ex_src[gi]);
            assign wb_fwd[gi]       = ex_q.valid && ex_use[gi] &&
                                      dest_hit(wb_q.valid, wb_q.wb_en, wb_q.rd, ex_src[gi]);

            assign fwd_sel[gi] = mem_fwd[gi] ? 2'b01 :
                                 wb_fwd[gi]  ? 2'b10 : 2'b00;
        end
    endgenerate

    assign load_use   = active && bus.id_valid && (|id_load_hit);
    assign redirect   = active && bus.ex_redirect;
    // Redirect wins over load-use so the PC is free to take the target.
    assign stall_id_w = hold_all || (load_use && !redirect);
    assign accept_id  = bus.id_valid && !stall_id_w && !redirect;

    assign bus.stall_if        = stall_id_w;
    assign bus.stall_id        = stall_id_w;
    assign bus.stall_ex        = hold_all;
    assign bus.stall_mem       = hold_all;
    assign bus.bubble_wb       = hold_all;
    assign bus.flush_id        = redirect;
    assign bus.bubble_ex       = redirect || load_use;
    assign bus.fwd_a_sel       = fwd_sel[0];
    assign bus.fwd_b_sel       = fwd_sel[1];
    assign bus.mem_timeout_err = in_error;
    assign bus.stall_cnt       = stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                RUN, MEM_WAIT: begin
                    if (bus.mem_busy) begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                        if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1))
                            state_reg <= ERROR;
                        else
                            state_reg <= MEM_WAIT;
                    end else begin
                        wait_cnt_reg <= '0;
                        state_reg    <= RUN;
                    end
                end
                default: state_reg <= ERROR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (active) begin
            wb_q.valid    <= mem_q.valid;
            wb_q.rd       <= mem_q.rd;
            wb_q.wb_en    <= mem_q.wb_en;
            mem_q.valid   <= ex_q.valid;
            mem_q.rd      <= ex_q.rd;
            mem_q.wb_en   <= ex_q.wb_en;
            mem_q.is_load <= ex_q.is_load;
            if (accept_id) begin
                ex_q.valid   <= 1'b1;
                ex_q.rd      <= bus.id_rd;
                ex_q.wb_en   <= bus.id_wb_en;
                ex_q.is_load <= (bus.id_wb_sel == 2'b01);
                ex_q.rs1     <= bus.id_rs1;
                ex_q.rs2     <= bus.id_rs2;
                ex_q.use_rs1 <= bus.id_use_rs1;
                ex_q.use_rs2 <= bus.id_use_rs2;
            end else begin
                ex_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_reg <= '0;
        else if (stall_id_w && (stall_cnt_reg != {CNT_W{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end

    a_no_mem_load_forward : assert property (
        @(posedge clk) disable iff (!rst_n) (mem_load_hit == 2'b00)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl: one table of per-cycle ID inputs with
// expected controls, followed by timeout/ERROR and asynchronous reset sequences.
module tb_hazard_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hazard_ctrl_if #(.CNT_W(32)) bus ();

    hazard_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // {stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, bubble_wb}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_RD   = 7'b0000110;
    localparam logic [6:0] C_FRZ  = 7'b1111001;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [1:0] use_;
        logic [4:0] rd;
        logic [1:0] sel;
        logic       redir;
        logic       busy;
        logic [6:0] ctrl;
        logic [1:0] fa;
        logic [1:0] fb;
        int         cnt;
    } vec_t;

    localparam int NVEC = 34;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [1:0] use_, input logic [4:0] rd, input logic [1:0] sel,
                                input logic redir, input logic busy, input logic [6:0] ctrl,
                                input logic [1:0] fa, input logic [1:0] fb, input int cnt);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.use_ = use_; r.rd = rd; r.sel = sel;
        r.redir = redir; r.busy = busy; r.ctrl = ctrl; r.fa = fa; r.fb = fb; r.cnt = cnt;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [1:0] use_, input logic [4:0] rd, input logic [1:0] sel,
                         input logic redir, input logic busy);
        bus.id_valid    = v;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_use_rs1  = use_[0];
        bus.id_use_rs2  = use_[1];
        bus.id_rd       = rd;
        bus.id_wb_en    = v;
        bus.id_wb_sel   = sel;
        bus.ex_redirect = redir;
        bus.mem_busy    = busy;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [6:0] ctrl, input logic [1:0] fa,
                             input logic [1:0] fb, input int cnt, input logic err);
        logic [6:0] c;
        c = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
             bus.flush_id, bus.bubble_ex, bus.bubble_wb};
        $display("%s: ctrl=%b fwd_a=%b fwd_b=%b stall_cnt=%0d err=%b",
                 tag, c, bus.fwd_a_sel, bus.fwd_b_sel, bus.stall_cnt, bus.mem_timeout_err);
        chk({tag, " ctrl"},  32'(c),                   32'(ctrl));
        chk({tag, " fwd_a"}, 32'(bus.fwd_a_sel),       32'(fa));
        chk({tag, " fwd_b"}, 32'(bus.fwd_b_sel),       32'(fb));
        chk({tag, " cnt"},   bus.stall_cnt,            32'(cnt));
        chk({tag, " err"},   32'(bus.mem_timeout_err), 32'(err));
    endtask

    initial begin
        // lw x5 ; add x6,x5,x7  -> one load-use stall, then WB forward
        vecs[0]  = mk(1, 1, 0, 2'b01, 5, 2'b01, 0, 0, C_NONE, 2'b00, 2'b00, 0);
        vecs[1]  = mk(1, 5, 7, 2'b11, 6, 2'b00, 0, 0, C_LU,   2'b00, 2'b00, 0);
        vecs[2]  = mk(1, 5, 7, 2'b11, 6, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 1);
        vecs[3]  = mk(0, 0, 0, 2'b00, 0, 2'b00, 0, 0, C_NONE, 2'b10, 2'b00, 1);
        // add x3 ; sub x4,x3,x3 -> MEM forward on both operands
        vecs[4]  = mk(1, 1, 2, 2'b11, 3, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 1);
        vecs[5]  = mk(1, 3, 3, 2'b11, 4, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 1);
        vecs[6]  = mk(0, 0, 0, 2'b00, 0, 2'b00, 0, 0, C_NONE, 2'b01, 2'b01, 1);
        // add x8 ; add x9 ; sub x12,x8,x8 -> WB forward on both operands
        vecs[7]  = mk(1, 1, 2, 2'b11, 8, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 1);
        vecs[8]  = mk(1, 10, 11, 2'b11, 9, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 1);
        vecs[9]  = mk(1, 8, 8, 2'b11, 12, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 1);
        vecs[10] = mk(0, 0, 0, 2'b00, 0, 2'b00, 0, 0, C_NONE, 2'b10, 2'b10, 1);
        // lw x0 ; add x13,x0,x0 -> no stall, no forward
        vecs[11] = mk(1, 1, 0, 2'b01, 0, 2'b01, 0, 0, C_NONE, 2'b00, 2'b00, 1);
        vecs[12] = mk(1, 0, 0, 2'b11, 13, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 1);
        vecs[13] = mk(0, 0, 0, 2'b00, 0, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 1);
        // redirect together with a load-use hazard
        vecs[14] = mk(1, 1, 0, 2'b01, 5, 2'b01, 0, 0, C_NONE, 2'b00, 2'b00, 1);
        vecs[15] = mk(1, 5, 5, 2'b11, 6, 2'b00, 1, 0, C_RD,   2'b00, 2'b00, 1);
        vecs[16] = mk(0, 0, 0, 2'b00, 0, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 1);
        // three busy cycles with redirect pending, redirect lands afterwards
        vecs[17] = mk(1, 1, 2, 2'b11, 14, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 1);
        vecs[18] = mk(1, 14, 1, 2'b11, 15, 2'b00, 1, 1, C_FRZ, 2'b00, 2'b00, 1);
        vecs[19] = mk(1, 14, 1, 2'b11, 15, 2'b00, 1, 1, C_FRZ, 2'b00, 2'b00, 2);
        vecs[20] = mk(1, 14, 1, 2'b11, 15, 2'b00, 1, 1, C_FRZ, 2'b00, 2'b00, 3);
        vecs[21] = mk(1, 14, 1, 2'b11, 15, 2'b00, 1, 0, C_RD,  2'b00, 2'b00, 4);
        vecs[22] = mk(0, 0, 0, 2'b00, 0, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 4);
        // add x20 twice ; sub x21,x20,x1 -> MEM wins over WB
        vecs[23] = mk(1, 1, 2, 2'b11, 20, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 4);
        vecs[24] = mk(1, 1, 2, 2'b11, 20, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 4);
        vecs[25] = mk(1, 20, 1, 2'b11, 21, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 4);
        vecs[26] = mk(0, 0, 0, 2'b00, 0, 2'b00, 0, 0, C_NONE, 2'b01, 2'b00, 4);
        // lw x7 ; reader naming x7 in rs2 without using it -> no stall
        vecs[27] = mk(1, 1, 0, 2'b01, 7, 2'b01, 0, 0, C_NONE, 2'b00, 2'b00, 4);
        vecs[28] = mk(1, 9, 7, 2'b01, 8, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 4);
        vecs[29] = mk(0, 0, 0, 2'b00, 0, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 4);
        // lw x9 ; add x10,x1,x9 -> load-use through rs2, WB forward on B
        vecs[30] = mk(1, 1, 0, 2'b01, 9, 2'b01, 0, 0, C_NONE, 2'b00, 2'b00, 4);
        vecs[31] = mk(1, 1, 9, 2'b11, 10, 2'b00, 0, 0, C_LU,  2'b00, 2'b00, 4);
        vecs[32] = mk(1, 1, 9, 2'b11, 10, 2'b00, 0, 0, C_NONE, 2'b00, 2'b00, 5);
        vecs[33] = mk(0, 0, 0, 2'b00, 0, 2'b00, 0, 0, C_NONE, 2'b00, 2'b10, 5);

        drive(0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        check_all("reset", C_NONE, 2'b00, 2'b00, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].use_, vecs[i].rd,
                  vecs[i].sel, vecs[i].redir, vecs[i].busy);
            #2;
            check_all($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].fa, vecs[i].fb,
                      vecs[i].cnt, 1'b0);
        end

        // Timeout: four busy cycles freeze, then ERROR latches
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            drive(0, 0, 0, 2'b00, 0, 2'b00, 0, 1);
            #2;
            check_all($sformatf("busy%0d", b), C_FRZ, 2'b00, 2'b00, 5 + b, 1'b0);
        end
        @(negedge clk);
        drive(1, 1, 2, 2'b11, 3, 2'b00, 1, 0);
        #2;
        check_all("error0", C_FRZ, 2'b00, 2'b00, 9, 1'b1);
        @(negedge clk);
        drive(0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        #2;
        check_all("error1", C_FRZ, 2'b00, 2'b00, 10, 1'b1);

        // Asynchronous reset between clock edges clears everything at once
        drive(0, 0, 0, 2'b00, 0, 2'b00, 0, 1);
        rst_n = 1'b0;
        #1;
        check_all("async_rst", C_NONE, 2'b00, 2'b00, 0, 1'b0);
        @(negedge clk);
        drive(0, 0, 0, 2'b00, 0, 2'b00, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check_all("post_rst", C_NONE, 2'b00, 2'b00, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core. Sits beside the decode stage.
- Consumes the decoded register fields and writeback controls (`rd`, `wb_en`, `wb_sel`) of the instruction in ID.
- Tracks in-flight destinations in EX/MEM/WB and generates stall, bubble and forwarding controls for the IF/ID/EX/MEM stage registers.
- Also handles EX redirects, data-memory wait freezes, a memory-timeout error and a stall-cycle counter.

Parameters:
- `MEM_TIMEOUT`, default 256: consecutive `mem_busy` cycles after which ERROR is entered.
- `CNT_W`, default 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `id_valid`  in  1  valid instruction in ID
- `id_rs1`  in  5  source register 1 of the ID instruction
- `id_rs2`  in  5  source register 2 of the ID instruction
- `id_use_rs1`  in  1  ID instruction reads rs1
- `id_use_rs2`  in  1  ID instruction reads rs2
- `id_rd`  in  5  destination of the ID instruction
- `id_wb_en`  in  1  ID instruction writes back
- `id_wb_sel`  in  2  writeback source; 2'b01 = load data
- `ex_redirect`  in  1  taken branch/jump resolved in EX
- `mem_busy`  in  1  data memory not ready this cycle
- `stall_if`  out  1  hold PC
- `stall_id`  out  1  hold IF/ID register
- `stall_ex`  out  1  hold ID/EX register
- `stall_mem`  out  1  hold EX/MEM register
- `flush_id`  out  1  clear IF/ID register to NOP
- `bubble_ex`  out  1  load NOP into ID/EX
- `bubble_wb`  out  1  suppress register-file write this cycle
- `fwd_a_sel`  out  2  EX operand A source: 00 regfile, 01 MEM result, 10 WB data
- `fwd_b_sel`  out  2  EX operand B source, same encoding as `fwd_a_sel`
- `mem_timeout_err`  out  1  sticky error flag
- `stall_cnt`  out  `CNT_W`  count of cycles with `stall_id` = 1

Behaviour:
- Internal tracking registers `ex_q`, `mem_q`, `wb_q`, each holding {valid, rd, wb_en, is_load}.
  - `ex_q` additionally holds rs1/rs2 and use bits.
  - `is_load` = (`wb_sel` == 2'b01).
- Reset (async, `rst_n` low):
  - All tracking valid bits = 0; FSM = RUN; `stall_cnt` = 0; `mem_timeout_err` = 0.
  - All stall/flush/bubble outputs = 0; `fwd_*_sel` = 00.
  - Reset mid-operation discards all tracked state immediately.
- Tracking register update on advance (RUN, not frozen):
  - `wb_q` <= `mem_q`; `mem_q` <= `ex_q`.
  - `ex_q` <= ID fields when `id_valid` && !`stall_id` && !`flush_id`; otherwise `ex_q` <= bubble (valid = 0).
- Hazard match rules:
  - A tracked entry matches source r only when valid && `wb_en` && rd == r && r != 0.
  - x0 never creates a hazard or a forward.
- Load-use stall (RUN): `id_valid` && `ex_q` is a load matching (rs1 && `use_rs1`) or (rs2 && `use_rs2`).
  - Assert `stall_if`, `stall_id` and `bubble_ex` for exactly one cycle.
  - The next cycle the load is in MEM; by the time the consumer reaches EX, the load is in WB and forwards from WB.
- Redirect: `ex_redirect` = 1 in RUN asserts `flush_id` and `bubble_ex` in the same cycle.
  - Redirect overrides the load-use stall: `stall_if`/`stall_id` = 0 so the PC takes the target.
- Forwarding (combinational from `ex_q` vs `mem_q`/`wb_q`):
  - MEM match (non-load) gives 01; else WB match gives 10; else 00.
  - MEM has priority over WB when both match.
  - A load in MEM never forwards 01 (unreachable by construction; assertion required).
- FSM:
  - RUN -> MEM_WAIT when `mem_busy` = 1.
  - MEM_WAIT -> RUN when `mem_busy` = 0.
  - MEM_WAIT -> ERROR when the wait counter reaches `MEM_TIMEOUT`.
  - ERROR is terminal until reset.
- Freeze: `mem_busy` = 1 (in RUN or MEM_WAIT) is a combinational freeze.
  - `stall_if`/`stall_id`/`stall_ex`/`stall_mem` = 1 and `bubble_wb` = 1.
  - `flush_id` = 0, `bubble_ex` = 0; tracking registers hold.
  - Freeze dominates redirect and load-use; EX holds the redirect, which takes effect on the first unfrozen cycle.
- Wait counter: cleared when `mem_busy` = 0, incremented each busy cycle.
  - Counter = `MEM_TIMEOUT`-1 while busy -> ERROR next cycle.
- ERROR: `mem_timeout_err` = 1; all four stalls and `bubble_wb` held at 1 regardless of inputs.
- `stall_cnt`: increments every cycle `stall_id` = 1, including freeze and ERROR; saturates at all-ones.

Test Plan:
- `lw x5` then `add x6,x5,x7` back-to-back:
  - One cycle of `stall_if`/`stall_id`/`bubble_ex` = 1.
  - `add` in EX gets `fwd_a_sel` = 10; `stall_cnt` = 1.
- `add x3,...`; `sub x4,x3,x3` -> no stall; `sub` in EX has `fwd_a_sel` = `fwd_b_sel` = 01.
  - With an unrelated instruction inserted between them: both = 10.
- `lw x0` followed by a reader of x0 -> no stall, `fwd_*_sel` = 00.
- `ex_redirect` = 1 in the same cycle as a load-use hazard:
  - `flush_id` = 1, `bubble_ex` = 1, `stall_if` = 0.
- `mem_busy` for 3 cycles with `ex_redirect` = 1:
  - All stalls and `bubble_wb` = 1 for 3 cycles, `flush_id` = 0.
  - The cycle after `mem_busy` falls: `flush_id` = 1.
- `MEM_TIMEOUT` = 4, `mem_busy` held high:
  - ERROR entered after 4 busy cycles; `mem_timeout_err` = 1 and stays set after `mem_busy` = 0.
  - Cleared only by `rst_n` low, asynchronously.
